// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// alu_arbiter_if : requester and alu_ext signal bundle around alu_arbiter
// Rev 1.0
// ============================================================================
interface alu_arbiter_if;
  // Requester side
  logic        req0;
  logic        req1;
  logic [15:0] instr0;
  logic [15:0] instr1;
  logic [15:0] a0;
  logic [15:0] a1;
  logic [15:0] b0;
  logic [15:0] b1;
  logic        gnt0;
  logic        gnt1;
  logic        done;
  logic        done_id;
  logic [15:0] result;
  logic        err;
  logic [2:0]  flags0;
  logic [2:0]  flags1;
  // alu_ext side
  logic [15:0] alu_r0;
  logic [15:0] alu_r1;
  logic [15:0] alu_r2;
  logic [7:0]  alu_instr;
  logic [1:0]  alu_src;
  logic [2:0]  alu_op;
  logic [1:0]  shf_op;
  logic        alu_llb;
  logic        alu_lhb;
  logic        alu_as;
  logic [15:0] alu_result;
  logic        alu_n;
  logic        alu_v;
  logic        alu_z;

  // Arbiter view
  modport slave (
    input  req0, req1, instr0, instr1, a0, a1, b0, b1,
    output gnt0, gnt1, done, done_id, result, err, flags0, flags1,
    output alu_r0, alu_r1, alu_r2, alu_instr, alu_src, alu_op, shf_op,
    output alu_llb, alu_lhb, alu_as,
    input  alu_result, alu_n, alu_v, alu_z
  );

  // Requesters plus alu_ext view
  modport master (
    output req0, req1, instr0, instr1, a0, a1, b0, b1,
    input  gnt0, gnt1, done, done_id, result, err, flags0, flags1,
    input  alu_r0, alu_r1, alu_r2, alu_instr, alu_src, alu_op, shf_op,
    input  alu_llb, alu_lhb, alu_as,
    output alu_result, alu_n, alu_v, alu_z
  );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// alu_arbiter : round-robin sharing of one alu_ext between two requesters
// Rev 1.0
// ============================================================================
module alu_arbiter (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_PADDSB = 4'h1;
  localparam logic [3:0] OP_SUB    = 4'h2;
  localparam logic [3:0] OP_NAND   = 4'h3;
  localparam logic [3:0] OP_XOR    = 4'h4;
  localparam logic [3:0] OP_SLL    = 4'h5;
  localparam logic [3:0] OP_SRL    = 4'h6;
  localparam logic [3:0] OP_SRA    = 4'h7;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;

  logic [1:0]  state_q, state_d;
  logic        last_q, last_d;
  logic        win_q, win_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        done_q, done_d;
  logic        done_id_q, done_id_d;
  logic        err_q, err_d;
  logic [15:0] result_q, result_d;
  logic [2:0]  flags0_q, flags0_d;
  logic [2:0]  flags1_q, flags1_d;

  // instr[11:8] is carried through the operand latch but has no meaning here
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr_q[11:8];

  logic [3:0] opcode;
  assign opcode = instr_q[15:12];

  logic       dec_legal;
  logic       dec_wr_nvz;
  logic       dec_wr_z;
  logic [1:0] dec_src;
  logic [2:0] dec_op;
  logic [1:0] dec_shf;
  logic       dec_llb;
  logic       dec_lhb;
  logic       dec_as;

  always_comb begin
    dec_legal  = 1'b1;
    dec_wr_nvz = 1'b0;
    dec_wr_z   = 1'b0;
    dec_src    = 2'b00;
    dec_op     = 3'b000;
    dec_shf    = 2'b00;
    dec_llb    = 1'b0;
    dec_lhb    = 1'b0;
    dec_as     = 1'b0;
    case (opcode)
      OP_ADD, OP_PADDSB, OP_SUB: begin
        dec_op     = opcode[2:0];
        dec_src    = 2'b01;
        dec_wr_nvz = 1'b1;
      end
      OP_NAND, OP_XOR: begin
        dec_op   = opcode[2:0];
        dec_src  = 2'b01;
        dec_wr_z = 1'b1;
      end
      OP_SLL: begin dec_shf = 2'b00; dec_as = 1'b1; dec_wr_z = 1'b1; end
      OP_SRL: begin dec_shf = 2'b01; dec_as = 1'b1; dec_wr_z = 1'b1; end
      OP_SRA: begin dec_shf = 2'b11; dec_as = 1'b1; dec_wr_z = 1'b1; end
      OP_LLB: begin dec_llb = 1'b1; dec_as = 1'b1; end
      // LHB passes rs through the adder (plus zero) so alu_ext can keep its low byte
      OP_LHB: begin dec_lhb = 1'b1; dec_op = 3'b000; dec_src = 2'b00; end
      default: dec_legal = 1'b0;
    endcase
  end

  logic in_exec;
  assign in_exec = (state_q == S_EXEC);

  assign bus.alu_r0    = 16'h0000;
  assign bus.alu_r1    = in_exec ? a_q          : 16'h0000;
  assign bus.alu_r2    = in_exec ? b_q          : 16'h0000;
  assign bus.alu_instr = in_exec ? instr_q[7:0] : 8'h00;
  assign bus.alu_src   = in_exec ? dec_src      : 2'b00;
  assign bus.alu_op    = in_exec ? dec_op       : 3'b000;
  assign bus.shf_op    = in_exec ? dec_shf      : 2'b00;
  assign bus.alu_llb   = in_exec & dec_llb;
  assign bus.alu_lhb   = in_exec & dec_lhb;
  assign bus.alu_as    = in_exec & dec_as;

  // On a tie the requester that was not served last wins
  logic any_req;
  logic pick;
  assign any_req = bus.req0 | bus.req1;
  assign pick    = (bus.req0 & bus.req1) ? ~last_q : bus.req1;

  logic [2:0] cur_flags;
  logic [2:0] new_flags;
  always_comb begin
    cur_flags = win_q ? flags1_q : flags0_q;
    new_flags = cur_flags;
    if (dec_wr_nvz)
      new_flags = {bus.alu_n, bus.alu_v, bus.alu_z};
    else if (dec_wr_z)
      new_flags = {cur_flags[2:1], bus.alu_z};
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    win_d     = win_q;
    instr_d   = instr_q;
    a_d       = a_q;
    b_d       = b_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    err_d     = 1'b0;
    result_d  = result_q;
    flags0_d  = flags0_q;
    flags1_d  = flags1_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          win_d   = pick;
          last_d  = pick;
          instr_d = pick ? bus.instr1 : bus.instr0;
          a_d     = pick ? bus.a1     : bus.a0;
          b_d     = pick ? bus.b1     : bus.b0;
          gnt0_d  = ~pick;
          gnt1_d  = pick;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        done_d    = 1'b1;
        done_id_d = win_q;
        err_d     = ~dec_legal;
        result_d  = dec_legal ? bus.alu_result : 16'h0000;
        if (win_q) flags1_d = new_flags;
        else       flags0_d = new_flags;
        state_d   = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      win_q     <= 1'b0;
      instr_q   <= 16'h0000;
      a_q       <= 16'h0000;
      b_q       <= 16'h0000;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      err_q     <= 1'b0;
      result_q  <= 16'h0000;
      flags0_q  <= 3'b000;
      flags1_q  <= 3'b000;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      win_q     <= win_d;
      instr_q   <= instr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      err_q     <= err_d;
      result_q  <= result_d;
      flags0_q  <= flags0_d;
      flags1_q  <= flags1_d;
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.err     = err_q;
  assign bus.result  = result_q;
  assign bus.flags0  = flags0_q;
  assign bus.flags1  = flags1_q;

endmodule
`default_nettype wire
